alarm_cpu_debug_ocimem: RTL

- On-chip debug memory controller on the sysclk side of the Nios II debug slave.
- Consumes jdo and the ocimem take_action/take_no_action strobes from the debug slave wrapper.
- Serves JTAG read/write access to a private debug RAM and returns read data on MonDReg, which feeds the debug slave's TCK scan chain.
- Arbitrates the same RAM against an Avalon-MM slave port used by the CPU debug monitor. JTAG has priority.

---
 rtl/alarm_cpu_debug_ocimem.sv | 91 +++++++++
 1 files changed

// File: rtl/alarm_cpu_debug_ocimem.sv
// alarm_cpu_debug_ocimem: debug RAM shared by JTAG (ocimem strobes, MonAReg/MonDReg)
// and an Avalon-MM slave port; JTAG always wins arbitration.
module alarm_cpu_debug_ocimem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              jtag_busy,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [31:0]       readdata,
  output logic              waitrequest
);
  typedef enum logic [1:0] {IDLE, JRD, AVRD} state_t;
  state_t state_q, state_d;
  logic rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d, av_done_q, av_done_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d, jaddr, inc, base;
  logic [31:0] mon_d_q, mon_d_d, readdata_q, readdata_d;
  logic [31:0] mem [2**ADDR_W];
  logic [31:0] ram_q, ram_wdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0] ram_be;
  logic ram_we, strobe, jtag_act, idle, wr_go, jrd_go, av_ok, avrd_go, avwr_go;
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};
  always_comb begin
    strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    jtag_act = rd_pend_q | wr_pend_q | strobe;
    idle = state_q == IDLE;
    wr_go = idle & wr_pend_q;
    jrd_go = idle & !wr_pend_q & rd_pend_q;
    av_ok = idle & !jtag_act;
    avrd_go = av_ok & read & !av_done_q;
    avwr_go = av_ok & !read & write & debugaccess;
    ram_we = wr_go | avwr_go;
    ram_addr = (wr_go | jrd_go) ? mon_a_q : address;
    ram_wdata = wr_go ? mon_d_q : writedata;
    ram_be = wr_go ? 4'hF : byteenable;
    state_d = jrd_go ? JRD : avrd_go ? AVRD : IDLE;
    jaddr = ADDR_W'(jdo[33:26]);
    inc = mon_a_q + 1'b1;
    base = wr_go ? inc : mon_a_q;
    mon_a_d = (take_action_ocimem_a & !take_action_ocimem_b) ? jaddr :
              (take_no_action_ocimem_a & !take_action_ocimem_a & !take_action_ocimem_b) ? inc : base;
    mon_d_d = take_action_ocimem_b ? jdo[34:3] : (state_q == JRD) ? ram_q : mon_d_q;
    wr_pend_d = take_action_ocimem_b | (wr_pend_q & !wr_go);
    rd_pend_d = (!take_action_ocimem_b & ((take_action_ocimem_a & jdo[35]) |
                (take_no_action_ocimem_a & !take_action_ocimem_a))) | (rd_pend_q & !jrd_go);
    // Completed Avalon read is held until the JTAG side lets the master see waitrequest low
    av_done_d = (state_q == AVRD) | (av_done_q & !av_ok);
    readdata_d = (state_q == AVRD) ? ram_q : readdata_q;
  end
  assign waitrequest = !reset_n | !idle | jtag_act | (read & !av_done_q);
  assign jtag_busy = rd_pend_q | wr_pend_q | (state_q == JRD);
  assign MonDReg = mon_d_q;
  assign MonAReg = mon_a_q;
  assign readdata = readdata_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      rd_pend_q <= 1'b0;
      wr_pend_q <= 1'b0;
      av_done_q <= 1'b0;
      mon_a_q <= '0;
      mon_d_q <= '0;
      readdata_q <= '0;
    end else begin
      state_q <= state_d;
      rd_pend_q <= rd_pend_d;
      wr_pend_q <= wr_pend_d;
      av_done_q <= av_done_d;
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
      readdata_q <= readdata_d;
    end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_we & ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    ram_q <= mem[ram_addr];
  end
endmodule
